// File: rtl/disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// disp_scan_ctrl
//
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// The controller holds one 32-bit display frame and presents one digit per
// scan slot to the downstream combinational digit/anode decoder:
//   digit_val -> decoder 'a' input (4-bit digit value)
//   digit_sel -> decoder 'b' input (3-bit digit index)
//
// New frames arrive through a load strobe. While scanning, a loaded frame is
// parked in a shadow register and committed on the 7->0 wrap. This means a
// frame is never shown half old and half new. With the scan frozen (en=0),
// or when a load lands exactly on the wrap edge, the frame is committed
// straight into the display registers.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   en          in   scan enable; 0 freezes divider and digit index
//   load        in   single-cycle new-frame strobe
//   data_in     in   [31:0] frame; digit k = data_in[4k+3:4k]
//   blank_in    in   [7:0] blank mask; bit k = 1 blanks digit k
//   digit_val   out  [3:0] current digit value (registered)
//   digit_sel   out  [2:0] current digit index (registered)
//   digit_blank out  current digit blanked (registered)
//   frame_done  out  one-cycle pulse following each 7->0 wrap
//   pending     out  a loaded frame is waiting in the shadow register
// -----------------------------------------------------------------------------
module disp_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  blank_in,
    output logic [3:0]  digit_val,
    output logic [2:0]  digit_sel,
    output logic        digit_blank,
    output logic        frame_done,
    output logic        pending
);

    localparam int              DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);
    localparam logic [2:0]      SEL_LAST = 3'(NUM_DIGITS - 1);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    // State registers
    logic [DIV_W-1:0] div_cnt_reg,     div_cnt_next;
    logic [2:0]       sel_reg,         sel_next;
    logic [31:0]      disp_data_reg,   disp_data_next;
    logic [7:0]       disp_mask_reg,   disp_mask_next;
    logic [31:0]      shadow_data_reg, shadow_data_next;
    logic [7:0]       shadow_mask_reg, shadow_mask_next;
    logic [0:0]       state_reg,       state_next;
    logic [3:0]       val_reg,         val_next;
    logic             blank_reg,       blank_next;
    logic             frame_done_reg,  frame_done_next;

    logic advance;
    logic wrap;

    // Nibble view of the frame that will be on display after this edge.
    // Output registers are fed from the *next* frame/index so that a commit
    // and an index step both show up on the very same edge.
    logic [3:0] nibble_next [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_nibble
        assign nibble_next[gi] = disp_data_next[4*gi +: 4];
    end

    always_comb begin
        advance = en && (div_cnt_reg == DIV_MAX);
        wrap    = advance && (sel_reg == SEL_LAST);
    end

    // Divider and digit index
    always_comb begin
        div_cnt_next = div_cnt_reg;
        sel_next     = sel_reg;
        if (en) begin
            if (advance) begin
                div_cnt_next = '0;
                sel_next     = sel_reg + 3'd1;   // 3-bit rollover gives 7 -> 0
            end else begin
                div_cnt_next = div_cnt_reg + DIV_W'(1);
            end
        end
    end

    // Commit FSM. Priority: a load that cannot be safely deferred (scan frozen
    // or landing on the wrap itself) goes straight to the display and drops
    // anything in the shadow; otherwise a load parks in the shadow (last load
    // wins); a parked frame moves to the display on the wrap.
    always_comb begin
        state_next       = state_reg;
        disp_data_next   = disp_data_reg;
        disp_mask_next   = disp_mask_reg;
        shadow_data_next = shadow_data_reg;
        shadow_mask_next = shadow_mask_reg;

        if (load && (!en || wrap)) begin
            disp_data_next = data_in;
            disp_mask_next = blank_in;
            state_next     = ST_IDLE;
        end else if (load) begin
            shadow_data_next = data_in;
            shadow_mask_next = blank_in;
            state_next       = ST_PENDING;
        end else if ((state_reg == ST_PENDING) && wrap) begin
            disp_data_next = shadow_data_reg;
            disp_mask_next = shadow_mask_reg;
            state_next     = ST_IDLE;
        end
    end

    always_comb begin
        val_next        = nibble_next[sel_next];
        blank_next      = disp_mask_next[sel_next];
        frame_done_next = wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_reg     <= '0;
            sel_reg         <= '0;
            disp_data_reg   <= '0;
            disp_mask_reg   <= 8'hFF;
            shadow_data_reg <= '0;
            shadow_mask_reg <= '0;
            state_reg       <= ST_IDLE;
            val_reg         <= '0;
            blank_reg       <= 1'b1;
            frame_done_reg  <= 1'b0;
        end else begin
            div_cnt_reg     <= div_cnt_next;
            sel_reg         <= sel_next;
            disp_data_reg   <= disp_data_next;
            disp_mask_reg   <= disp_mask_next;
            shadow_data_reg <= shadow_data_next;
            shadow_mask_reg <= shadow_mask_next;
            state_reg       <= state_next;
            val_reg         <= val_next;
            blank_reg       <= blank_next;
            frame_done_reg  <= frame_done_next;
        end
    end

    assign digit_val   = val_reg;
    assign digit_sel   = sel_reg;
    assign digit_blank = blank_reg;
    assign frame_done  = frame_done_reg;
    assign pending     = (state_reg == ST_PENDING);

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_disp_scan_ctrl
//
// Directed bench for disp_scan_ctrl with REFRESH_DIV=4. The stimulus process
// drives inputs on falling edges and queues the expected output snapshot for
// a given rising-edge count; the monitor process samples the outputs on every
// falling edge and pops and compares the entries that fall due.
// -----------------------------------------------------------------------------
module tb_disp_scan_ctrl;

    typedef struct {
        int         cyc;
        logic [2:0] sel;
        logic [3:0] val;
        logic       blank;
        logic       fd;
        logic       pend;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [31:0] data_in;
    logic [7:0]  blank_in;
    logic [3:0]  digit_val;
    logic [2:0]  digit_sel;
    logic        digit_blank;
    logic        frame_done;
    logic        pending;

    int    cyc = 0;        // rising edges seen so far
    int    n_total = 0;
    int    n_pass = 0;
    int    b = 0;          // edge count when scanning is first enabled
    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_n;

    disp_scan_ctrl #(
        .REFRESH_DIV(4),
        .NUM_DIGITS (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .data_in    (data_in),
        .blank_in   (blank_in),
        .digit_val  (digit_val),
        .digit_sel  (digit_sel),
        .digit_blank(digit_blank),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that is due at this falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            n_total++;
            if (mon_e.cyc != cyc) begin
                $display("FAIL %s: expectation for edge %0d missed (now edge %0d)",
                         mon_n, mon_e.cyc, cyc);
            end else if (digit_sel === mon_e.sel && digit_val === mon_e.val &&
                         digit_blank === mon_e.blank && frame_done === mon_e.fd &&
                         pending === mon_e.pend) begin
                n_pass++;
                $display("ok   %-16s edge %0d sel=%0d val=%h blank=%b fd=%b pend=%b",
                         mon_n, cyc, digit_sel, digit_val, digit_blank, frame_done, pending);
            end else begin
                $display("FAIL %s edge %0d: got sel=%0d val=%h blank=%b fd=%b pend=%b, want sel=%0d val=%h blank=%b fd=%b pend=%b",
                         mon_n, cyc, digit_sel, digit_val, digit_blank, frame_done, pending,
                         mon_e.sel, mon_e.val, mon_e.blank, mon_e.fd, mon_e.pend);
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Queue the expected outputs as seen after rising edge number c.
    task automatic chk(input int c, input logic [2:0] sel, input logic [3:0] val,
                       input logic blank, input logic fd, input logic pend,
                       input string nm);
        exp_t e;
        wait_until(c - 1);
        e.cyc = c; e.sel = sel; e.val = val; e.blank = blank; e.fd = fd; e.pend = pend;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0; data_in = '0; blank_in = '0;

        // 1. Reset held for 3 edges
        chk(3, 3'd0, 4'h0, 1'b1, 1'b0, 1'b0, "reset");
        wait_until(3);

        // 2. Frozen-scan load commits directly
        rst_n = 1'b1; load = 1'b1; data_in = 32'h7654_3210; blank_in = 8'h00;
        chk(4, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0, "direct_commit");
        wait_until(4);
        load = 1'b0; en = 1'b1;
        b = cyc;
        chk(b + 3, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0, "div_hold");
        for (int k = 1; k < 8; k++)
            chk(b + 4*k, 3'(k), 4'(k), 1'b0, 1'b0, 1'b0, "scan_f1");
        chk(b + 32, 3'd0, 4'h0, 1'b0, 1'b1, 1'b0, "wrap_f1");
        chk(b + 33, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0, "fd_pulse_end");

        // 3. Mid-frame load at digit 3 is deferred to the wrap
        wait_until(b + 45);
        load = 1'b1; data_in = 32'hFEDC_BA98; blank_in = 8'h81;
        chk(b + 46, 3'd3, 4'h3, 1'b0, 1'b0, 1'b1, "pend_set");
        wait_until(b + 46);
        load = 1'b0;
        for (int k = 4; k < 8; k++)
            chk(b + 32 + 4*k, 3'(k), 4'(k), 1'b0, 1'b0, 1'b1, "old_frame_kept");
        chk(b + 64, 3'd0, 4'h8, 1'b1, 1'b1, 1'b0, "new_frame_d0");
        chk(b + 68, 3'd1, 4'h9, 1'b0, 1'b0, 1'b0, "new_frame_d1");
        chk(b + 92, 3'd7, 4'hF, 1'b1, 1'b0, 1'b0, "new_frame_d7");

        // 4. Load landing exactly on the wrap edge
        chk(b + 95, 3'd7, 4'hF, 1'b1, 1'b0, 1'b0, "pre_wrap_load");
        wait_until(b + 95);
        load = 1'b1; data_in = 32'h0000_000A; blank_in = 8'h00;
        chk(b + 96, 3'd0, 4'hA, 1'b0, 1'b1, 1'b0, "wrap_load");
        wait_until(b + 96);
        load = 1'b0;
        chk(b + 100, 3'd1, 4'h0, 1'b0, 1'b0, 1'b0, "wrap_load_d1");

        // 5. Freeze at digit 5 with div_cnt=2
        wait_until(b + 118);
        en = 1'b0;
        chk(b + 119, 3'd5, 4'h0, 1'b0, 1'b0, 1'b0, "frozen_a");
        chk(b + 128, 3'd5, 4'h0, 1'b0, 1'b0, 1'b0, "frozen_b");
        chk(b + 138, 3'd5, 4'h0, 1'b0, 1'b0, 1'b0, "frozen_c");
        wait_until(b + 138);
        en = 1'b1;
        chk(b + 139, 3'd5, 4'h0, 1'b0, 1'b0, 1'b0, "resume_wait");
        chk(b + 140, 3'd6, 4'h0, 1'b0, 1'b0, 1'b0, "resume_step");

        // 6. Reset while a frame is pending discards it
        wait_until(b + 141);
        load = 1'b1; data_in = 32'h1234_5678; blank_in = 8'h00;
        chk(b + 142, 3'd6, 4'h0, 1'b0, 1'b0, 1'b1, "pend_before_rst");
        wait_until(b + 142);
        load = 1'b0; rst_n = 1'b0;
        chk(b + 143, 3'd0, 4'h0, 1'b1, 1'b0, 1'b0, "mid_reset");
        wait_until(b + 143);
        rst_n = 1'b1;
        for (int k = 1; k < 8; k++)
            chk(b + 143 + 4*k, 3'(k), 4'h0, 1'b1, 1'b0, 1'b0, "discarded");
        chk(b + 175, 3'd0, 4'h0, 1'b1, 1'b1, 1'b0, "wrap_after_rst");

        wait_until(b + 177);
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            n_total++;
            $display("FAIL %s: expectation for edge %0d never checked", mon_n, mon_e.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
